// File: rtl/serial_cfg_slave.sv
// serial_cfg_slave: responder for the host serial configuration bus.
// Oversamples SEN/SCLK/SDI on clk_120mhz, decodes 40-bit MSB-first frames
// (R/W flag, address, data), commits writes as a one-cycle strobe and
// shifts readback data out on SDO for read frames.
module serial_cfg_slave #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_120mhz,
    input  logic              reset,
    input  logic              SEN,
    input  logic              SCLK,
    input  logic              SDI,
    output logic              SDO,
    output logic              sdo_oe,
    output logic [ADDR_W-1:0] serial_addr,
    output logic [DATA_W-1:0] serial_data,
    output logic              serial_strobe,
    output logic [ADDR_W-1:0] rb_addr,
    input  logic [DATA_W-1:0] rb_data,
    output logic              frame_err
);

    localparam int unsigned HDR_W   = ADDR_W + 1;
    localparam int unsigned FRAME_W = HDR_W + DATA_W;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
    localparam int unsigned FILL_W  = $clog2(SYNC_STAGES + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WR,
        RD,
        DONE
    } state_t;

    // synchronizer chains and edge-detect history
    logic [SYNC_STAGES-1:0] sen_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sen_prev;
    logic                   sclk_prev;
    logic [FILL_W-1:0]      fill;
    logic                   filled;
    logic                   sen_s;
    logic                   sclk_s;

    // combinational edge detects and their held flags
    logic sen_fall_det;
    logic sen_rise_det;
    logic sclk_rise_det;
    logic sclk_fall_det;
    logic sen_fall_f;
    logic sen_rise_f;
    logic sclk_rise_f;
    logic sclk_fall_f;
    logic sdi_bit;
    logic hold_flags;

    // frame state
    state_t            state;
    state_t            state_n;
    logic              armed;
    logic              armed_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [CNT_W-1:0]  cnt_inc;
    logic              len_ok;
    logic [HDR_W-1:0]  hdr_sr;
    logic [HDR_W-1:0]  hdr_n;
    logic [DATA_W-1:0] data_sr;
    logic [DATA_W-1:0] data_n;
    logic [DATA_W-1:0] out_sr;
    logic [DATA_W-1:0] out_n;
    logic              rd_load;
    logic              rd_load_n;

    // next values of registered outputs
    logic              sdo_oe_n;
    logic [ADDR_W-1:0] serial_addr_n;
    logic [DATA_W-1:0] serial_data_n;
    logic              serial_strobe_n;
    logic [ADDR_W-1:0] rb_addr_n;
    logic              frame_err_n;

    assign sen_s         = sen_sync[SYNC_STAGES-1];
    assign sclk_s        = sclk_sync[SYNC_STAGES-1];
    assign filled        = (fill == FILL_W'(SYNC_STAGES));
    assign sen_fall_det  = sen_prev & ~sen_s;
    assign sen_rise_det  = ~sen_prev & sen_s;
    assign sclk_rise_det = ~sclk_prev & sclk_s;
    assign sclk_fall_det = sclk_prev & ~sclk_s;
    assign hold_flags    = (state == DONE);
    assign SDO           = out_sr[DATA_W-1];

    // Pad synchronizers; fill tracks when the last stage carries real pad samples
    always_ff @(posedge clk_120mhz) begin
        if (reset) begin
            sen_sync  <= '1;
            sclk_sync <= '0;
            sdi_sync  <= '0;
            sen_prev  <= 1'b1;
            sclk_prev <= 1'b0;
            fill      <= '0;
        end else begin
            sen_sync[0]  <= SEN;
            sclk_sync[0] <= SCLK;
            sdi_sync[0]  <= SDI;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sen_sync[i]  <= sen_sync[i-1];
                sclk_sync[i] <= sclk_sync[i-1];
                sdi_sync[i]  <= sdi_sync[i-1];
            end
            sen_prev  <= sen_s;
            sclk_prev <= sclk_s;
            if (!filled) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

    // Edge flags: one-cycle pulses, stretched across DONE so IDLE still sees them
    always_ff @(posedge clk_120mhz) begin
        if (reset) begin
            sen_fall_f  <= 1'b0;
            sen_rise_f  <= 1'b0;
            sclk_rise_f <= 1'b0;
            sclk_fall_f <= 1'b0;
            sdi_bit     <= 1'b0;
        end else begin
            sen_fall_f  <= sen_fall_det  | (sen_fall_f  & hold_flags);
            sen_rise_f  <= sen_rise_det  | (sen_rise_f  & hold_flags);
            sclk_rise_f <= sclk_rise_det | (sclk_rise_f & hold_flags);
            sclk_fall_f <= sclk_fall_det | (sclk_fall_f & hold_flags);
            if (sclk_rise_det) begin
                sdi_bit <= sdi_sync[SYNC_STAGES-1];
            end
        end
    end

    // Frame state and registered outputs
    always_ff @(posedge clk_120mhz) begin
        if (reset) begin
            state         <= IDLE;
            armed         <= 1'b0;
            cnt           <= '0;
            hdr_sr        <= '0;
            data_sr       <= '0;
            out_sr        <= '0;
            rd_load       <= 1'b0;
            sdo_oe        <= 1'b0;
            serial_addr   <= '0;
            serial_data   <= '0;
            serial_strobe <= 1'b0;
            rb_addr       <= '0;
            frame_err     <= 1'b0;
        end else begin
            state         <= state_n;
            armed         <= armed_n;
            cnt           <= cnt_n;
            hdr_sr        <= hdr_n;
            data_sr       <= data_n;
            out_sr        <= out_n;
            rd_load       <= rd_load_n;
            sdo_oe        <= sdo_oe_n;
            serial_addr   <= serial_addr_n;
            serial_data   <= serial_data_n;
            serial_strobe <= serial_strobe_n;
            rb_addr       <= rb_addr_n;
            frame_err     <= frame_err_n;
        end
    end

    // Next-state and output decode; commit/error outcome is decided on sen_rise
    always_comb begin
        state_n         = state;
        armed_n         = armed | (filled & sen_s);
        cnt_n           = cnt;
        hdr_n           = hdr_sr;
        data_n          = data_sr;
        out_n           = out_sr;
        rd_load_n       = 1'b0;
        sdo_oe_n        = sdo_oe;
        serial_addr_n   = serial_addr;
        serial_data_n   = serial_data;
        serial_strobe_n = 1'b0;
        rb_addr_n       = rb_addr;
        frame_err_n     = 1'b0;
        cnt_inc         = (cnt == CNT_W'(CNT_MAX)) ? cnt : cnt + CNT_W'(1);
        len_ok          = (cnt == CNT_W'(FRAME_W));

        case (state)
            IDLE: begin
                if (sen_fall_f && armed) begin
                    state_n = ADDR;
                    armed_n = 1'b0;
                    cnt_n   = '0;
                    hdr_n   = '0;
                    data_n  = '0;
                end
            end

            ADDR: begin
                if (sen_rise_f) begin
                    state_n     = DONE;
                    frame_err_n = 1'b1;
                end else if (cnt == CNT_W'(HDR_W)) begin
                    if (hdr_sr[HDR_W-1]) begin
                        state_n   = RD;
                        rb_addr_n = hdr_sr[ADDR_W-1:0];
                        rd_load_n = 1'b1;
                    end else begin
                        state_n = WR;
                    end
                end else if (sclk_rise_f) begin
                    hdr_n = {hdr_sr[HDR_W-2:0], sdi_bit};
                    cnt_n = cnt_inc;
                end
            end

            WR: begin
                if (sen_rise_f) begin
                    state_n  = DONE;
                    sdo_oe_n = 1'b0;
                    out_n    = '0;
                    if (len_ok) begin
                        serial_addr_n   = hdr_sr[ADDR_W-1:0];
                        serial_data_n   = data_sr;
                        serial_strobe_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end else if (sclk_rise_f) begin
                    data_n = {data_sr[DATA_W-2:0], sdi_bit};
                    cnt_n  = cnt_inc;
                end
            end

            RD: begin
                if (sen_rise_f) begin
                    state_n     = DONE;
                    sdo_oe_n    = 1'b0;
                    out_n       = '0;
                    frame_err_n = ~len_ok;
                end else begin
                    // First RD cycle grabs readback data; the header's last fall
                    // must not shift, so shifting starts once a data bit has risen.
                    if (rd_load) begin
                        out_n    = rb_data;
                        sdo_oe_n = 1'b1;
                    end else if (sclk_fall_f && (cnt > CNT_W'(HDR_W))) begin
                        out_n = {out_sr[DATA_W-2:0], 1'b0};
                    end
                    if (sclk_rise_f) begin
                        cnt_n = cnt_inc;
                    end
                end
            end

            DONE: begin
                state_n  = IDLE;
                sdo_oe_n = 1'b0;
                out_n    = '0;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_cfg_slave.sv
// Testbench for serial_cfg_slave: directed table of frames plus randomized
// frames checked against a frame-level model of the config bus.
module tb_serial_cfg_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        sen;
    logic        sclk;
    logic        sdi;
    logic        sdo;
    logic        sdo_oe;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;
    logic [6:0]  rb_addr;
    logic [31:0] rb_data;
    logic        frame_err;

    logic [31:0] rb_mem [0:127];

    always #5 clk = ~clk;

    assign rb_data = rb_mem[rb_addr];

    serial_cfg_slave dut (
        .clk_120mhz    (clk),
        .reset         (reset),
        .SEN           (sen),
        .SCLK          (sclk),
        .SDI           (sdi),
        .SDO           (sdo),
        .sdo_oe        (sdo_oe),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .serial_strobe (serial_strobe),
        .rb_addr       (rb_addr),
        .rb_data       (rb_data),
        .frame_err     (frame_err)
    );

    // Event monitor: counts strobes/errors and logs each committed write
    int          n_strobe = 0;
    int          n_err    = 0;
    logic [6:0]  log_addr [0:255];
    logic [31:0] log_data [0:255];

    always @(posedge clk) begin
        #1;
        if (serial_strobe === 1'b1) begin
            log_addr[n_strobe % 256] = serial_addr;
            log_data[n_strobe % 256] = serial_data;
            n_strobe++;
        end
        if (frame_err === 1'b1) n_err++;
    end

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          rw;
        logic [6:0]  addr;
        logic [31:0] data;
        int          nbits;
        int          gap;
        bit          co;
        int          rst_at;
        int          e_str;
        int          e_err;
        logic [6:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] e_sdo;
    } vec_t;

    // Bus master: drives SDI on SCLK low, samples SDO just before each rise
    task automatic send_frame(input logic [63:0] bits, input int nbits, input int half,
                              input bit co, input int rst_at,
                              output logic [31:0] sdo_word, output logic oe_seen);
        sdo_word = '0;
        oe_seen  = 1'b0;
        @(negedge clk);
        sen  = 1'b0;
        sclk = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                reset = 1'b1;
                repeat (3) @(negedge clk);
                reset = 1'b0;
            end
            sdi  = bits[nbits-1-i];
            sclk = 1'b0;
            repeat (half) @(negedge clk);
            if (i >= 8 && i < 40) sdo_word = {sdo_word[30:0], sdo};
            if (i == 8) oe_seen = sdo_oe;
            sclk = 1'b1;
            repeat (half) @(negedge clk);
        end
        sclk = 1'b0;
        repeat (half) @(negedge clk);
        if (co) sclk = 1'b1;
        sen = 1'b1;
    endtask

    task automatic run_frame(input vec_t v, input int half, input string tag);
        logic [39:0] f;
        logic [63:0] bits;
        logic [31:0] sdo_word;
        logic        oe_seen;
        int          s0;
        int          e0;
        f  = {v.rw, v.addr, v.data};
        if (v.nbits <= 40) begin
            bits = 64'(f) >> (40 - v.nbits);
        end else begin
            bits = (64'(f) << (v.nbits - 40)) |
                   (64'($urandom) & ((64'd1 << (v.nbits - 40)) - 64'd1));
        end
        s0 = n_strobe;
        e0 = n_err;
        send_frame(bits, v.nbits, half, v.co, v.rst_at, sdo_word, oe_seen);
        repeat (v.gap) @(negedge clk);
        sclk = 1'b0;
        chk({tag, " strobes"}, 64'(n_strobe - s0), 64'(v.e_str));
        chk({tag, " frame_err"}, 64'(n_err - e0), 64'(v.e_err));
        if (v.e_str == 1 && n_strobe > s0) begin
            chk({tag, " strobe_addr"}, 64'(log_addr[(n_strobe - 1) % 256]), 64'(v.e_addr));
            chk({tag, " strobe_data"}, 64'(log_data[(n_strobe - 1) % 256]), 64'(v.e_data));
        end
        chk({tag, " serial_addr"}, 64'(serial_addr), 64'(v.e_addr));
        chk({tag, " serial_data"}, 64'(serial_data), 64'(v.e_data));
        if (v.rw && v.nbits >= 8 && v.rst_at < 0)
            chk({tag, " rb_addr"}, 64'(rb_addr), 64'(v.addr));
        if (v.rw && v.nbits == 40 && v.rst_at < 0) begin
            chk({tag, " sdo_word"}, 64'(sdo_word), 64'(v.e_sdo));
            chk({tag, " sdo_oe_during"}, 64'(oe_seen), 64'd1);
        end
        chk({tag, " sdo_oe_after"}, 64'(sdo_oe), 64'd0);
        chk({tag, " sdo_after"}, 64'(sdo), 64'd0);
    endtask

    vec_t        tab [9];
    logic [6:0]  m_addr;
    logic [31:0] m_data;

    initial begin
        vec_t v;
        reset = 1'b1;
        sen   = 1'b1;
        sclk  = 1'b0;
        sdi   = 1'b0;
        for (int a = 0; a < 128; a++) rb_mem[a] = $urandom;
        rb_mem[7'h20] = 32'hDEADBEEF;

        //         rw addr   data          n   gap co rst str err e_addr e_data        e_sdo
        tab[0] = '{1'b0, 7'h05, 32'h01234567, 40, 6, 1'b0, -1, 1, 0, 7'h05, 32'h01234567, 32'h0};
        tab[1] = '{1'b1, 7'h20, 32'h00000000, 40, 6, 1'b0, -1, 0, 0, 7'h05, 32'h01234567, 32'hDEADBEEF};
        tab[2] = '{1'b0, 7'h11, 32'hCAFEF00D, 39, 6, 1'b0, -1, 0, 1, 7'h05, 32'h01234567, 32'h0};
        tab[3] = '{1'b0, 7'h12, 32'h0BADBEEF, 41, 6, 1'b0, -1, 0, 1, 7'h05, 32'h01234567, 32'h0};
        tab[4] = '{1'b0, 7'h33, 32'h12345678, 40, 6, 1'b0, 20, 0, 0, 7'h00, 32'h00000000, 32'h0};
        tab[5] = '{1'b0, 7'h44, 32'h87654321, 40, 6, 1'b0, -1, 1, 0, 7'h44, 32'h87654321, 32'h0};
        tab[6] = '{1'b0, 7'h01, 32'hAAAA5555, 40, 4, 1'b0, -1, 1, 0, 7'h01, 32'hAAAA5555, 32'h0};
        tab[7] = '{1'b0, 7'h7F, 32'h00000001, 40, 6, 1'b0, -1, 1, 0, 7'h7F, 32'h00000001, 32'h0};
        tab[8] = '{1'b0, 7'h6A, 32'h5A5A5A5A, 40, 6, 1'b1, -1, 1, 0, 7'h6A, 32'h5A5A5A5A, 32'h0};

        repeat (4) @(negedge clk);
        chk("rst SDO", 64'(sdo), 64'd0);
        chk("rst sdo_oe", 64'(sdo_oe), 64'd0);
        chk("rst serial_addr", 64'(serial_addr), 64'd0);
        chk("rst serial_data", 64'(serial_data), 64'd0);
        chk("rst serial_strobe", 64'(serial_strobe), 64'd0);
        chk("rst rb_addr", 64'(rb_addr), 64'd0);
        chk("rst frame_err", 64'(frame_err), 64'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            run_frame(tab[k], 4, $sformatf("tab%0d", k));
        end
        m_addr = 7'h6A;
        m_data = 32'h5A5A5A5A;

        // Randomized frames against the frame-level model
        for (int k = 0; k < 40; k++) begin
            int r;
            v.rw   = 1'($urandom);
            v.addr = 7'($urandom);
            v.data = $urandom;
            r      = int'($urandom_range(0, 9));
            if (r < 6)       v.nbits = 40;
            else if (r == 6) v.nbits = 39;
            else if (r == 7) v.nbits = 41;
            else             v.nbits = int'($urandom_range(2, 45));
            v.gap    = int'($urandom_range(4, 10));
            v.co     = ($urandom_range(0, 3) == 0);
            v.rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, v.nbits - 1)) : -1;
            if (v.rst_at >= 0) begin
                v.e_str = 0;
                v.e_err = 0;
                m_addr  = '0;
                m_data  = '0;
            end else begin
                v.e_str = (!v.rw && v.nbits == 40) ? 1 : 0;
                v.e_err = (v.nbits != 40) ? 1 : 0;
                if (v.e_str == 1) begin
                    m_addr = v.addr;
                    m_data = v.data;
                end
            end
            v.e_addr = m_addr;
            v.e_data = m_data;
            v.e_sdo  = rb_mem[v.addr];
            run_frame(v, int'($urandom_range(4, 5)), $sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
